// File: rtl/dm_cache_ctrl_if.sv
// rtl/dm_cache_ctrl_if.sv - shared types and CPU/tag/data/memory port bundle for the cache controller
package dm_cache_pkg;
    localparam int ADDR_W = 32;
    localparam int BLK_W  = 128;
    localparam int WORD_W = 32;
    localparam int TAG_W  = ADDR_W - 7;

    typedef struct packed {
        logic [2:0] index;
        logic       we;
    } cache_req_type;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_type;
endpackage

interface dm_cache_ctrl_if;
    import dm_cache_pkg::*;

    logic                cpu_valid;
    logic                cpu_rw;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [WORD_W-1:0]   cpu_wdata;
    logic [WORD_W-1:0]   cpu_rdata;
    logic                cpu_ready;

    cache_req_type       tag_req;
    cache_tag_type       tag_write;
    cache_tag_type       tag_read;

    logic [2:0]          data_idx;
    logic                data_we;
    logic [BLK_W-1:0]    data_write;
    logic [BLK_W-1:0]    data_read;

    logic                mem_valid;
    logic                mem_rw;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BLK_W-1:0]    mem_wdata;
    logic [BLK_W-1:0]    mem_rdata;
    logic                mem_ready;

    // Controller side
    modport master (
        input  cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        output tag_req, tag_write,
        input  tag_read,
        output data_idx, data_we, data_write,
        input  data_read,
        output mem_valid, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // CPU, tag/data memories and memory bus side
    modport slave (
        output cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        input  tag_req, tag_write,
        output tag_read,
        input  data_idx, data_we, data_write,
        output data_read,
        input  mem_valid, mem_rw, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - 8-block direct-mapped cache controller FSM (hit check, write-back, allocate)
module dm_cache_ctrl #(
    parameter int ADDR_W = dm_cache_pkg::ADDR_W,
    parameter int BLK_W  = dm_cache_pkg::BLK_W,
    parameter int WORD_W = dm_cache_pkg::WORD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    dm_cache_ctrl_if.master bus
);
    localparam int TAG_W = ADDR_W - 7;
    localparam int WSH   = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t              state;
    logic                req_rw;
    logic [ADDR_W-1:2]   req_addr;
    logic [WORD_W-1:0]   req_wdata;
    logic [ADDR_W-1:0]   victim_addr;
    logic [BLK_W-1:0]    victim_data;

    logic [TAG_W-1:0]    req_tag;
    logic [2:0]          req_index;
    logic [1:0]          req_word;
    logic [WSH+1:0]      word_lsb;
    logic                hit;
    logic                victim_dirty;
    logic                unused_addr_bits;

    // Byte offset bits never influence a word access
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    assign req_tag      = req_addr[ADDR_W-1:7];
    assign req_index    = req_addr[6:4];
    assign req_word     = req_addr[3:2];
    assign word_lsb     = {req_word, {WSH{1'b0}}};
    assign hit          = bus.tag_read.valid && (bus.tag_read.tag == req_tag);
    assign victim_dirty = bus.tag_read.valid && bus.tag_read.dirty;

    // State register plus latched request and captured victim
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_rw      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            victim_addr <= '0;
            victim_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_valid) begin
                        req_rw    <= bus.cpu_rw;
                        req_addr  <= bus.cpu_addr[ADDR_W-1:2];
                        req_wdata <= bus.cpu_wdata;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        state <= IDLE;
                    end else if (victim_dirty) begin
                        victim_addr <= {bus.tag_read.tag, req_index, 4'b0000};
                        victim_data <= bus.data_read;
                        state       <= WRITE_BACK;
                    end else begin
                        state <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (bus.mem_ready) begin
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        state <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from state; memory writes happen in the cycle the tag check or fill resolves
    always_comb begin
        bus.cpu_ready     = 1'b0;
        bus.cpu_rdata     = '0;
        bus.tag_req.index = req_index;
        bus.tag_req.we    = 1'b0;
        bus.tag_write     = '0;
        bus.data_idx      = req_index;
        bus.data_we       = 1'b0;
        bus.data_write    = '0;
        bus.mem_valid     = 1'b0;
        bus.mem_rw        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        case (state)
            COMPARE: begin
                if (hit) begin
                    bus.cpu_ready = 1'b1;
                    if (req_rw) begin
                        bus.data_we                        = 1'b1;
                        bus.data_write                     = bus.data_read;
                        bus.data_write[word_lsb +: WORD_W] = req_wdata;
                        bus.tag_req.we                     = 1'b1;
                        bus.tag_write                      = {1'b1, 1'b1, req_tag};
                    end else begin
                        bus.cpu_rdata = bus.data_read[word_lsb +: WORD_W];
                    end
                end
            end
            WRITE_BACK: begin
                bus.mem_valid = 1'b1;
                bus.mem_rw    = 1'b1;
                bus.mem_addr  = victim_addr;
                bus.mem_wdata = victim_data;
            end
            ALLOCATE: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = {req_addr[ADDR_W-1:4], 4'b0000};
                if (bus.mem_ready) begin
                    bus.data_we    = 1'b1;
                    bus.data_write = bus.mem_rdata;
                    bus.tag_req.we = 1'b1;
                    bus.tag_write  = {1'b1, 1'b0, req_tag};
                end
            end
            default: ;
        endcase
    end
endmodule
